// File: rtl/weight_loader_pkg.sv
// Shared types and constants for the weight loading path.
// Buffer depth and kernel limits are common to the buffers and PE array.
package weight_loader_pkg;

  typedef enum logic [1:0] {
    WL_IDLE = 2'd0,
    WL_LOAD = 2'd1,
    WL_DONE = 2'd2
  } wl_state_e;

  localparam int WL_DATA_WIDTH = 16;
  localparam int WL_NUM_ROWS   = 4;
  localparam int WL_MAX_KERNEL = 16;
  localparam int WL_BUF_DEPTH  = WL_MAX_KERNEL;
  localparam int WL_CNT_W      = 8;

endpackage

// File: rtl/weight_loader_row_onehot_dec.sv
// Binary row index to one-hot buffer write enable.
// All outputs are held low when the write strobe is idle.
module row_onehot_dec
  import weight_loader_pkg::*;
#(
  parameter int NUM_ROWS = WL_NUM_ROWS
) (
  input  logic [WL_CNT_W-1:0] row_cnt_i,
  input  logic                wr_en_i,
  output logic [NUM_ROWS-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      onehot_o[i] = wr_en_i &&
        (row_cnt_i == WL_CNT_W'(i));
    end
  end

endmodule

// File: rtl/weight_loader.sv
// Streams kernel_size words into each of num_rows weight buffers,
// row by row, then pulses done for the PE controller.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int DATA_WIDTH = WL_DATA_WIDTH,
  parameter int NUM_ROWS   = WL_NUM_ROWS,
  parameter int MAX_KERNEL = WL_MAX_KERNEL
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [7:0]            kernel_size,
  input  logic [7:0]            num_rows,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic [NUM_ROWS-1:0]   row_flush,
  output logic [DATA_WIDTH-1:0] row_data,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  localparam logic [8:0] MaxK = 9'(MAX_KERNEL);
  localparam logic [8:0] MaxR = 9'(NUM_ROWS);

  wl_state_e state_q, state_d;
  logic [WL_CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [WL_CNT_W-1:0] row_cnt_q, row_cnt_d;
  logic [WL_CNT_W-1:0] ks_q, ks_d;
  logic [WL_CNT_W-1:0] nr_q, nr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [NUM_ROWS-1:0] flush_q, flush_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic beat, cfg_bad, last_word, last_row;

  assign cfg_bad = (kernel_size == 8'd0) ||
                   ({1'b0, kernel_size} > MaxK) ||
                   (num_rows == 8'd0) ||
                   ({1'b0, num_rows} > MaxR);

  // abort wins over a same-cycle beat
  assign s_ready   = (state_q == WL_LOAD) && !abort;
  assign beat      = s_valid && s_ready;
  assign last_word = (word_cnt_q == ks_q - 8'd1);
  assign last_row  = (row_cnt_q == nr_q - 8'd1);

  row_onehot_dec #(
    .NUM_ROWS (NUM_ROWS)
  ) u_dec (
    .row_cnt_i (row_cnt_q),
    .wr_en_i   (beat),
    .onehot_o  (flush_d)
  );

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    row_cnt_d  = row_cnt_q;
    ks_d       = ks_q;
    nr_d       = nr_q;
    data_d     = data_q;
    done_d     = (state_q == WL_DONE);
    err_d      = 1'b0;
    unique case (state_q)
      WL_IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            err_d = 1'b1;
          end else begin
            ks_d       = kernel_size;
            nr_d       = num_rows;
            word_cnt_d = '0;
            row_cnt_d  = '0;
            state_d    = WL_LOAD;
          end
        end
      end
      WL_LOAD: begin
        if (abort) begin
          state_d = WL_IDLE;
        end else if (beat) begin
          data_d = s_data;
          if (last_word) begin
            word_cnt_d = '0;
            row_cnt_d  = row_cnt_q + 8'd1;
            if (last_row) state_d = WL_DONE;
          end else begin
            word_cnt_d = word_cnt_q + 8'd1;
          end
        end
      end
      WL_DONE: state_d = WL_IDLE;
      default: state_d = WL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WL_IDLE;
      word_cnt_q <= '0;
      row_cnt_q  <= '0;
      ks_q       <= '0;
      nr_q       <= '0;
      data_q     <= '0;
      flush_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      row_cnt_q  <= row_cnt_d;
      ks_q       <= ks_d;
      nr_q       <= nr_d;
      data_q     <= data_d;
      flush_q    <= flush_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign row_flush = flush_q;
  assign row_data  = data_q;
  assign busy      = (state_q == WL_LOAD);
  assign done      = done_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_weight_loader.sv
// Directed and randomized loads checked against a row/word model
// built from kernel_size, num_rows and the streamed words.
module tb_weight_loader;

  localparam int DW = 16;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic [7:0] kernel_size, num_rows;
  logic s_valid;
  logic [DW-1:0] s_data;
  logic s_ready;
  logic [NR-1:0] row_flush;
  logic [DW-1:0] row_data;
  logic busy, done, cfg_err;

  weight_loader #(
    .DATA_WIDTH (DW),
    .NUM_ROWS   (NR),
    .MAX_KERNEL (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .kernel_size (kernel_size),
    .num_rows    (num_rows),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .row_flush   (row_flush),
    .row_data    (row_data),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NR-1:0] f;
    logic [DW-1:0] d;
    int            c;
  } wr_t;

  wr_t wr_q[$];
  int  done_q[$];

  always @(negedge clk) begin
    if (row_flush != '0) wr_q.push_back('{row_flush, row_data, cyc});
    if (done) done_q.push_back(cyc);
  end

  logic [DW-1:0] words[$];
  int acc_q[$];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic gen_words(int n, bit seq);
    words.delete();
    for (int k = 0; k < n; k++)
      words.push_back(seq ? DW'(k + 1) : DW'($urandom));
  endtask

  task automatic do_start(int ks, int nr);
    @(posedge clk); #1;
    start = 1'b1;
    kernel_size = 8'(ks);
    num_rows = 8'(nr);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: continuous, 1: alternate, 2: random valid
  task automatic stream(int n, int mode, int abort_at);
    int i = 0;
    int budget = 2000;
    bit tog = 1'b1;
    acc_q.delete();
    while (i < n && budget > 0) begin
      budget--;
      case (mode)
        0: s_valid = 1'b1;
        1: begin s_valid = tog; tog = ~tog; end
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      s_data = words[i];
      abort = (i == abort_at);
      @(negedge clk);
      if (s_valid && s_ready) begin
        acc_q.push_back(cyc + 1);
        i++;
      end
      @(posedge clk); #1;
      if (abort) begin
        abort = 1'b0;
        break;
      end
    end
    s_valid = 1'b0;
    chk("beats", 64'(i), 64'(abort_at >= 0 ? abort_at : n));
  endtask

  task automatic verify(string tag, int bw, int bd, int ks, int nb, bit exp_done);
    int nw;
    logic [NR-1:0] ef;
    repeat (4) @(posedge clk);
    #1;
    nw = wr_q.size() - bw;
    chk({tag, "_nwr"}, 64'(nw), 64'(nb));
    for (int k = 0; k < nb && k < nw && k < acc_q.size(); k++) begin
      ef = NR'(1 << (k / ks));
      chk({tag, "_flush"}, 64'(wr_q[bw + k].f), 64'(ef));
      chk({tag, "_data"}, 64'(wr_q[bw + k].d), 64'(words[k]));
      chk({tag, "_wcyc"}, 64'(wr_q[bw + k].c), 64'(acc_q[k]));
    end
    chk({tag, "_ndone"}, 64'(done_q.size() - bd), 64'(exp_done));
    if (exp_done && done_q.size() > bd && acc_q.size() == nb)
      chk({tag, "_dcyc"}, 64'(done_q[bd]), 64'(acc_q[nb - 1] + 1));
    chk({tag, "_idle"}, {62'd0, busy, s_ready}, 64'd0);
  endtask

  task automatic load(string tag, int ks, int nr, int mode, bit seq);
    int bw, bd;
    gen_words(ks * nr, seq);
    bw = wr_q.size();
    bd = done_q.size();
    do_start(ks, nr);
    stream(ks * nr, mode, -1);
    verify(tag, bw, bd, ks, ks * nr, 1'b1);
  endtask

  initial begin
    int bw, bd, ks, nr;
    int bad_cfg[4][2] = '{'{0, 2}, '{17, 2}, '{3, 0}, '{3, 5}};
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    kernel_size = '0; num_rows = '0;
    s_valid = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outs",
        64'({s_ready, row_flush, row_data, busy, done, cfg_err}), 64'd0);

    load("nominal", 3, 2, 0, 1'b1);
    load("gaps", 3, 2, 1, 1'b1);

    for (int t = 0; t < 4; t++) begin
      do_start(bad_cfg[t][0], bad_cfg[t][1]);
      @(negedge clk);
      chk("cfg_err_pulse", 64'(cfg_err), 64'd1);
      chk("cfg_err_idle", {62'd0, busy, s_ready}, 64'd0);
      @(negedge clk);
      chk("cfg_err_once", 64'(cfg_err), 64'd0);
    end

    gen_words(16, 1'b0);
    bw = wr_q.size();
    bd = done_q.size();
    do_start(4, 4);
    stream(16, 0, 5);
    chk("abort_busy", 64'(busy), 64'd0);
    verify("abort", bw, bd, 4, 5, 1'b0);
    load("reload", 4, 4, 0, 1'b0);

    gen_words(6, 1'b0);
    do_start(3, 2);
    stream(2, 0, -1);
    rst = 1'b1;
    s_valid = 1'b1;
    s_data = words[2];
    @(posedge clk); #1;
    chk("rst_outs",
        64'({s_ready, row_flush, row_data, busy, done, cfg_err}), 64'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_noready", 64'({s_ready, row_flush, busy}), 64'd0);
    s_valid = 1'b0;

    bd = done_q.size();
    load("max", 16, 4, 0, 1'b0);
    if (done_q.size() > bd && acc_q.size() > 0)
      chk("max_done_lat", 64'(done_q[bd] - (acc_q[0] - 1)), 64'd65);

    for (int r = 0; r < 5; r++) begin
      ks = $urandom_range(1, 16);
      nr = $urandom_range(1, NR);
      load("rand", ks, nr, 2, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
